updown_counter_mod: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, parallel load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It replaces fixed-width free-running 0-to-15 counters wherever the design needs a configurable event, timer or index counter. It is a drop-in successor: with default parameters, `en=1`, `up=1`, `sat=0`, `load=0` and `clr=0`, it counts 0..15 and wraps, exactly like the 4-bit upcounter.

---
 rtl/updown_counter_pkg.sv | 20 ++
 rtl/updown_counter_mod_if.sv | 25 ++
 rtl/updown_counter_mod_prescaler.sv | 30 +++
 rtl/updown_counter_mod.sv | 79 +++++++
 tb/tb_updown_counter_mod.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the up/down counter.
package updown_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Load values above the modulus limit are pinned to max_val
  function automatic logic [31:0] clamp_to_max(input logic [31:0] val,
                                               input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control and status bundle of updown_counter_mod.
interface updown_counter_mod_if #(
  parameter int unsigned WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic             sat;
  logic             ovf_clr;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output clr, load, load_val, en, up, sat, ovf_clr,
    input  q, tc, ovf
  );

  modport slave (
    input  clr, load, load_val, en, up, sat, ovf_clr,
    output q, tc, ovf
  );
endinterface

// File: rtl/updown_counter_mod_prescaler.sv
// Step-tick divider: tick is high on every PRESCALE-th enabled cycle.
module cnt_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_cnt_q, pre_cnt_d;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tick      = en && (pre_cnt_q == LAST);
    if (clr) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pre_cnt_q <= '0;
    else     pre_cnt_q <= pre_cnt_d;
  end
endmodule

// File: rtl/updown_counter_mod.sv
// Up/down modulus counter with load, wrap/saturate, tc pulse and sticky ovf.
// Optional step prescaler enabled by defining UDCNT_PRESCALE_EN.
module updown_counter_mod
  import updown_counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX      = '1,
  parameter int unsigned      PRESCALE = 1
) (
  input logic                clk,
  input logic                rst,
  updown_counter_mod_if.slave bus
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_tick;
  logic             boundary;

`ifdef UDCNT_PRESCALE_EN
  // Load also restarts the prescale interval
  cnt_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clr | bus.load),
    .en   (bus.en),
    .tick (step_tick)
  );
`else
  logic prescale_unused;
  assign prescale_unused = (PRESCALE == 0);
  assign step_tick       = bus.en;
`endif

  always_comb begin
    q_d      = q_q;
    boundary = 1'b0;
    if (bus.clr) begin
      q_d = '0;
    end else if (bus.load) begin
      q_d = WIDTH'(clamp_to_max(32'(bus.load_val), 32'(MAX)));
    end else if (step_tick) begin
      if (bus.up == DIR_UP) begin
        if (q_q >= MAX) begin
          boundary = 1'b1;
          q_d      = (bus.sat == MODE_SAT) ? MAX : '0;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          boundary = 1'b1;
          q_d      = (bus.sat == MODE_SAT) ? '0 : MAX;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
    tc_d  = boundary;
    // A boundary event in the same cycle as ovf_clr keeps the flag set
    ovf_d = boundary ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod (WIDTH=4, MAX=9).
module tb_updown_counter_mod;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned MAXV  = 9;
`ifdef UDCNT_PRESCALE_EN
  localparam int unsigned PRESC = 3;
`else
  localparam int unsigned PRESC = 1;
`endif

  typedef struct {
    int unsigned q;
    bit          tc;
    bit          ovf;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  int unsigned m_q   = 0;
  bit          m_tc  = 0;
  bit          m_ovf = 0;
  int unsigned m_pre = 0;

  updown_counter_mod_if #(.WIDTH(WIDTH)) bus ();

  updown_counter_mod #(
    .WIDTH    (WIDTH),
    .MAX      (4'(MAXV)),
    .PRESCALE (PRESC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour, written in terms of modulus arithmetic
  task automatic model(input bit r, c, l, input int unsigned lv,
                       input bit e, u, s, oc);
    bit b = 0;
    if (r) begin
      m_q = 0; m_tc = 0; m_ovf = 0; m_pre = 0;
      return;
    end
    if (c) begin
      m_q = 0; m_pre = 0;
    end else if (l) begin
      m_q = (lv > MAXV) ? MAXV : lv; m_pre = 0;
    end else if (e) begin
      m_pre = (m_pre + 1) % PRESC;
      if (m_pre == 0) begin
        if (u) begin
          b = (m_q == MAXV);
          m_q = (b && s) ? MAXV : (m_q + 1) % (MAXV + 1);
        end else begin
          b = (m_q == 0);
          m_q = (b && s) ? 0 : (m_q + MAXV) % (MAXV + 1);
        end
      end
    end
    m_tc = b;
    if (b) m_ovf = 1;
    else if (oc) m_ovf = 0;
  endtask

  task automatic cyc(input string tag, input bit r, c, l, input int unsigned lv,
                     input bit e, u, s, oc);
    exp_t ex;
    exp_t got;
    rst          = r;
    bus.clr      = c;
    bus.load     = l;
    bus.load_val = 4'(lv);
    bus.en       = e;
    bus.up       = u;
    bus.sat      = s;
    bus.ovf_clr  = oc;
    model(r, c, l, lv, e, u, s, oc);
    ex.q = m_q; ex.tc = m_tc; ex.ovf = m_ovf; ex.tag = tag;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({got.tag, ".q"},   32'(bus.q),   32'(got.q));
    check({got.tag, ".tc"},  32'(bus.tc),  32'(got.tc));
    check({got.tag, ".ovf"}, 32'(bus.ovf), 32'(got.ovf));
  endtask

  // Count/load/clr shorthands: (tag, en, up, sat, ovf_clr)
  task automatic cnt(input string tag, input bit e, u, s, oc);
    cyc(tag, 0, 0, 0, 0, e, u, s, oc);
  endtask

  initial begin
    rst = 1'b1;
    bus.clr = 0; bus.load = 0; bus.load_val = '0; bus.en = 0;
    bus.up = 1; bus.sat = 0; bus.ovf_clr = 0;
    @(negedge clk);

    cyc("reset", 1, 0, 0, 0, 0, 1, 0, 0);
    check("reset_q_const", 32'(bus.q), 32'd0);

`ifdef UDCNT_PRESCALE_EN
    for (int i = 0; i < 9; i++) cnt("pre_run", 1, 1, 0, 0);
    check("pre_q_after9", 32'(bus.q), 32'd3);
    cnt("pre_mid", 1, 1, 0, 0);
    cnt("pre_hold", 0, 1, 0, 0);
    cnt("pre_hold", 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cnt("pre_resume", 1, 1, 0, 0);
    check("pre_q_resume", 32'(bus.q), 32'd4);
    cyc("pre_clr", 0, 1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cnt("pre_after_clr", 1, 1, 0, 0);
`else
    for (int i = 0; i < 12; i++) cnt("wrap_up", 1, 1, 0, 0);
    check("wrap_up_q_const", 32'(bus.q), 32'd2);

    cyc("load8", 0, 0, 1, 8, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) cnt("sat_up", 1, 1, 1, 0);
    check("sat_up_tc_const", 32'(bus.tc), 32'd1);
    cnt("en_off", 0, 1, 1, 0);

    cyc("load13", 0, 0, 1, 13, 0, 0, 0, 0);
    check("load13_q_const", 32'(bus.q), 32'd9);
    for (int i = 0; i < 11; i++) cnt("wrap_down", 1, 0, 0, 0);

    cyc("clr_load_en", 0, 1, 1, 3, 1, 1, 0, 0);
    cyc("load9", 0, 0, 1, 9, 1, 1, 0, 0);
    cnt("ovf_set_wins", 1, 1, 0, 1);
    check("ovf_set_wins_const", 32'(bus.ovf), 32'd1);
    cnt("ovf_clr", 0, 1, 0, 1);

    for (int i = 0; i < 5; i++) cnt("to5", 1, 1, 0, 0);
    cnt("dir_change", 1, 0, 0, 0);
    cnt("dir_back", 1, 1, 0, 0);
    cyc("rst_mid", 1, 0, 0, 0, 1, 1, 0, 0);

    for (int i = 0; i < 3; i++) cnt("sat_down", 1, 0, 1, 0);
    cnt("up_from0", 1, 1, 1, 0);
    cyc("load_plus_en", 0, 0, 1, 7, 1, 1, 0, 0);
    cnt("after_load", 1, 1, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
